// File: rtl/fwrisc_exec_formal_alu_checker.sv
// Tracks ALU/shift instructions from decode to retirement, checks writeback against a reference
// model, flags hangs and latches the first failure code. Coverage state is exported for cover properties.
module fwrisc_exec_formal_alu_checker #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT     = 16,
  parameter int COVER_COUNT = 2,
  parameter int CHECK_SHIFT = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            decode_valid,
  input  logic            instr_complete,
  input  logic [4:0]      op_type,
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [5:0]      rd,
  input  logic [5:0]      rd_waddr,
  input  logic [XLEN-1:0] rd_wdata,
  input  logic            rd_wen,
  output logic            check_fail,
  output logic [2:0]      fail_code,
  output logic [7:0]      instr_count,
  output logic            cover_hit,
  output logic            all_ops_covered,
  output logic            dbg_state
);

  // Op-type and ALU-op encodings shared with the exec unit.
  localparam logic [4:0] OP_TYPE_ARITH = 5'd0;
  localparam logic [4:0] OP_TYPE_SHIFT = 5'd1;
  localparam logic [5:0] OP_ADD = 6'd0,  OP_SUB = 6'd1,  OP_AND = 6'd2,  OP_OR  = 6'd3;
  localparam logic [5:0] OP_CLR = 6'd4,  OP_EQ  = 6'd5,  OP_LT  = 6'd6,  OP_LTU = 6'd7;
  localparam logic [5:0] OP_XOR = 6'd8,  OP_OPA = 6'd9,  OP_OPB = 6'd10;
  localparam logic [5:0] OP_SLL = 6'd11, OP_SRL = 6'd12, OP_SRA = 6'd13;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam int SHW = $clog2(XLEN);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [13:0] SHIFT_MASK = (CHECK_SHIFT != 0) ? 14'h0000 : 14'h3800;

  logic [0:0]      state;
  logic [1:0]      wcnt;
  logic [5:0]      waddr_q;
  logic [XLEN-1:0] wdata_q;
  logic [TW-1:0]   tcnt;
  logic [13:0]     bitmap;

  logic [1:0]      wcnt_m;
  logic [5:0]      waddr_m;
  logic [XLEN-1:0] wdata_m;
  logic [XLEN-1:0] model;
  logic [SHW-1:0]  shamt;
  logic            is_arith, is_shift, op_ok;
  logic [2:0]      chk_code;
  logic [7:0]      count_nxt;
  logic [13:0]     bitmap_nxt;

  assign dbg_state = state[0];

  always_comb begin
    // Merged view: a write in the completion cycle belongs to the retiring instruction.
    wcnt_m  = wcnt;
    waddr_m = waddr_q;
    wdata_m = wdata_q;
    if (rd_wen) begin
      wcnt_m  = (wcnt == 2'd3) ? 2'd3 : wcnt + 2'd1;
      waddr_m = rd_waddr;
      wdata_m = rd_wdata;
    end

    shamt = op_b[SHW-1:0];
    model = '0;
    case (op)
      OP_ADD: model = op_a + op_b;
      OP_SUB: model = op_a - op_b;
      OP_AND: model = op_a & op_b;
      OP_OR:  model = op_a | op_b;
      OP_CLR: model = op_b ^ (op_a & op_b);
      OP_EQ:  model = {{(XLEN-1){1'b0}}, op_a == op_b};
      OP_LT:  model = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_LTU: model = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_XOR: model = op_a ^ op_b;
      OP_OPA: model = op_a;
      OP_OPB: model = op_b;
      OP_SLL: model = op_a << shamt;
      OP_SRL: model = op_a >> shamt;
      OP_SRA: model = $signed(op_a) >>> shamt;
      default: model = '0;
    endcase

    is_arith = (op_type == OP_TYPE_ARITH);
    is_shift = (op_type == OP_TYPE_SHIFT) && (CHECK_SHIFT != 0);
    op_ok    = is_arith ? (op <= OP_OPB) : ((op >= OP_SLL) && (op <= OP_SRA));

    chk_code = 3'd0;
    if (state == ST_IDLE)                            chk_code = 3'd7;
    else if (!(is_arith || is_shift))                chk_code = 3'd5;
    else if (!op_ok)                                 chk_code = 3'd4;
    else if ((rd != 6'd0) ? (wcnt_m != 2'd1) : (wcnt_m > 2'd1))
                                                     chk_code = 3'd1;
    else if ((wcnt_m != 2'd0) && (waddr_m != rd))    chk_code = 3'd2;
    else if ((wcnt_m != 2'd0) && (wdata_m != model)) chk_code = 3'd3;

    count_nxt = (instr_count == 8'hFF) ? 8'hFF : instr_count + 8'd1;

    bitmap_nxt = bitmap;
    for (int i = 0; i < 14; i++) begin
      if ((chk_code == 3'd0) && (op == 6'(i))) bitmap_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      wcnt            <= 2'd0;
      waddr_q         <= 6'd0;
      wdata_q         <= '0;
      tcnt            <= '0;
      bitmap          <= 14'd0;
      check_fail      <= 1'b0;
      fail_code       <= 3'd0;
      instr_count     <= 8'd0;
      cover_hit       <= (COVER_COUNT == 0);
      all_ops_covered <= 1'b0;
    end else if (instr_complete) begin
      instr_count     <= count_nxt;
      cover_hit       <= (count_nxt == 8'(COVER_COUNT));
      bitmap          <= bitmap_nxt;
      all_ops_covered <= &(bitmap_nxt | SHIFT_MASK);
      if (!check_fail && (chk_code != 3'd0)) begin
        check_fail <= 1'b1;
        fail_code  <= chk_code;
      end
      // A decode in the retirement cycle starts the next instruction with fresh tracking.
      state <= decode_valid ? ST_ACTIVE : ST_IDLE;
      wcnt  <= 2'd0;
      tcnt  <= '0;
    end else if (state == ST_IDLE) begin
      if (decode_valid) begin
        state <= ST_ACTIVE;
        wcnt  <= 2'd0;
        tcnt  <= '0;
      end
    end else begin
      wcnt    <= wcnt_m;
      waddr_q <= waddr_m;
      wdata_q <= wdata_m;
      if (tcnt == TW'(TIMEOUT - 1)) begin
        state <= ST_IDLE;
        if (!check_fail) begin
          check_fail <= 1'b1;
          fail_code  <= 3'd6;
        end
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fwrisc_exec_formal_alu_checker.sv
// Bench for the exec ALU checker: table-driven retirements scored through an expected queue,
// plus hand sequences for hang, back-to-back, sticky-failure and reset corner cases.
module tb_fwrisc_exec_formal_alu_checker;

  localparam logic [4:0] T_ARITH = 5'd0;
  localparam logic [4:0] T_SHIFT = 5'd1;
  localparam logic [5:0] OP_ADD = 6'd0,  OP_SUB = 6'd1,  OP_AND = 6'd2,  OP_OR  = 6'd3;
  localparam logic [5:0] OP_CLR = 6'd4,  OP_EQ  = 6'd5,  OP_LT  = 6'd6,  OP_LTU = 6'd7;
  localparam logic [5:0] OP_XOR = 6'd8,  OP_OPA = 6'd9,  OP_OPB = 6'd10;
  localparam logic [5:0] OP_SLL = 6'd11, OP_SRL = 6'd12, OP_SRA = 6'd13;

  logic        clock = 1'b0;
  logic        reset, decode_valid, instr_complete, rd_wen;
  logic [4:0]  op_type;
  logic [5:0]  op, rd, rd_waddr;
  logic [31:0] op_a, op_b, rd_wdata;

  logic        check_fail, cover_hit, all_ops_covered, dbg_state;
  logic [2:0]  fail_code;
  logic [7:0]  instr_count;
  logic        ns_check_fail, ns_cover_hit, ns_all_ops_covered, ns_dbg_state;
  logic [2:0]  ns_fail_code;
  logic [7:0]  ns_instr_count;

  fwrisc_exec_formal_alu_checker #(.XLEN(32), .TIMEOUT(16), .COVER_COUNT(2), .CHECK_SHIFT(1)) dut (
    .clock(clock), .reset(reset), .decode_valid(decode_valid), .instr_complete(instr_complete),
    .op_type(op_type), .op(op), .op_a(op_a), .op_b(op_b), .rd(rd), .rd_waddr(rd_waddr),
    .rd_wdata(rd_wdata), .rd_wen(rd_wen), .check_fail(check_fail), .fail_code(fail_code),
    .instr_count(instr_count), .cover_hit(cover_hit), .all_ops_covered(all_ops_covered),
    .dbg_state(dbg_state));

  fwrisc_exec_formal_alu_checker #(.XLEN(32), .TIMEOUT(16), .COVER_COUNT(2), .CHECK_SHIFT(0)) dut_ns (
    .clock(clock), .reset(reset), .decode_valid(decode_valid), .instr_complete(instr_complete),
    .op_type(op_type), .op(op), .op_a(op_a), .op_b(op_b), .rd(rd), .rd_waddr(rd_waddr),
    .rd_wdata(rd_wdata), .rd_wen(rd_wen), .check_fail(ns_check_fail), .fail_code(ns_fail_code),
    .instr_count(ns_instr_count), .cover_hit(ns_cover_hit), .all_ops_covered(ns_all_ops_covered),
    .dbg_state(ns_dbg_state));

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  op_type;
    logic [5:0]  op;
    logic [31:0] a, b;
    logic [5:0]  rd;
    int          nwr;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    bit          wr_last;
    logic [2:0]  code;
  } vec_t;

  int          checks = 0;
  int          passed = 0;
  logic [11:0] exp_q[$];
  bit          chk_pending = 1'b0;
  bit          e_fail;
  logic [2:0]  e_code;
  int          e_cnt;

  function automatic logic [31:0] ref_alu(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_CLR: return a & ~b & 32'h0 | (b & ~a);
      OP_EQ:  return (a == b) ? 32'd1 : 32'd0;
      OP_LT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_LTU: return (a < b) ? 32'd1 : 32'd0;
      OP_XOR: return a ^ b;
      OP_OPA: return a;
      OP_OPB: return b;
      OP_SLL: return a << b[4:0];
      OP_SRL: return a >> b[4:0];
      OP_SRA: return 32'($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  function automatic vec_t mkv(input logic [4:0] t, input logic [5:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [5:0] r, input int n,
                               input logic [5:0] wa, input logic [31:0] wd, input bit wl,
                               input logic [2:0] c);
    vec_t v;
    v.op_type = t; v.op = o; v.a = a; v.b = b; v.rd = r; v.nwr = n;
    v.waddr = wa; v.wdata = wd; v.wr_last = wl; v.code = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock step; outputs are sampled 1ns after the edge and any pending retirement is scored.
  task automatic tick();
    logic [11:0] e;
    @(posedge clock);
    #1;
    if (chk_pending) begin
      chk_pending = 1'b0;
      if (exp_q.size() == 0) begin
        check("retire_queue_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("retire", {20'd0, check_fail, fail_code, instr_count}, {20'd0, e});
      end
    end
  endtask

  task automatic idle_inputs();
    decode_valid = 1'b0; instr_complete = 1'b0; rd_wen = 1'b0;
    op_type = T_ARITH; op = OP_ADD; op_a = 32'd0; op_b = 32'd0;
    rd = 6'd0; rd_waddr = 6'd0; rd_wdata = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    e_fail = 1'b0; e_code = 3'd0; e_cnt = 0;
  endtask

  // Drives one instruction; the expected sticky state after retirement goes on the queue.
  task automatic run_instr(input vec_t v, input bit skip_dec, input bit dec_at_end);
    int nb;
    op_type = v.op_type; op = v.op; op_a = v.a; op_b = v.b; rd = v.rd;
    if (!skip_dec) begin
      decode_valid = 1'b1;
      tick();
      decode_valid = 1'b0;
    end
    nb = v.nwr - (v.wr_last ? 1 : 0);
    for (int i = 0; i < nb; i++) begin
      rd_wen = 1'b1; rd_waddr = v.waddr; rd_wdata = v.wdata;
      tick();
      rd_wen = 1'b0;
    end
    instr_complete = 1'b1;
    decode_valid   = dec_at_end;
    if (v.wr_last) begin
      rd_wen = 1'b1; rd_waddr = v.waddr; rd_wdata = v.wdata;
    end
    e_cnt = (e_cnt >= 255) ? 255 : e_cnt + 1;
    if (!e_fail && (v.code != 3'd0)) begin
      e_fail = 1'b1;
      e_code = v.code;
    end
    exp_q.push_back({e_fail, e_code, 8'(e_cnt)});
    chk_pending = 1'b1;
    tick();
    instr_complete = 1'b0; decode_valid = 1'b0; rd_wen = 1'b0;
  endtask

  vec_t sweep[14];
  vec_t errs[8];
  vec_t v;
  logic [31:0] ra, rb;
  logic [5:0]  rr;

  initial begin
    // Stimulus tables
    for (int i = 0; i < 14; i++) begin
      ra = $urandom; rb = $urandom; rr = 6'($urandom_range(1, 31));
      if (i == int'(OP_EQ)) rb = ra;
      sweep[i] = mkv((i >= 11) ? T_SHIFT : T_ARITH, 6'(i), ra, rb, rr, 1, rr,
                     ref_alu(6'(i), ra, rb), 1'b0, 3'd0);
    end
    sweep[OP_LT]  = mkv(T_ARITH, OP_LT, 32'hFFFF_FFFF, 32'd0, 6'd0, 1, 6'd0, 32'd1, 1'b1, 3'd0);
    sweep[OP_SRA] = mkv(T_SHIFT, OP_SRA, 32'h8000_0000, 32'h21, 6'd9, 1, 6'd9, 32'hC000_0000, 1'b0, 3'd0);

    errs[0] = mkv(T_ARITH, 6'd20,  32'd1, 32'd2, 6'd5, 1, 6'd5, 32'd0, 1'b0, 3'd4);
    errs[1] = mkv(T_SHIFT, OP_ADD, 32'd1, 32'd2, 6'd5, 1, 6'd5, 32'd3, 1'b0, 3'd4);
    errs[2] = mkv(5'd2,    OP_ADD, 32'd1, 32'd2, 6'd5, 1, 6'd5, 32'd3, 1'b0, 3'd5);
    errs[3] = mkv(T_ARITH, OP_ADD, 32'd1, 32'd2, 6'd7, 1, 6'd8, 32'd3, 1'b0, 3'd2);
    errs[4] = mkv(T_ARITH, OP_ADD, 32'd1, 32'd2, 6'd7, 1, 6'd7, 32'd4, 1'b0, 3'd3);
    errs[5] = mkv(T_ARITH, OP_ADD, 32'd1, 32'd2, 6'd5, 0, 6'd5, 32'd3, 1'b0, 3'd1);
    errs[6] = mkv(T_ARITH, OP_OPA, 32'h55, 32'd2, 6'd0, 2, 6'd0, 32'h55, 1'b0, 3'd1);
    errs[7] = mkv(T_SHIFT, OP_SRA, 32'h8000_0000, 32'h21, 6'd9, 1, 6'd9, 32'h4000_0000, 1'b0, 3'd3);

    // Reset state
    do_reset();
    check("rst_check_fail", {31'd0, check_fail}, 32'd0);
    check("rst_fail_code", {29'd0, fail_code}, 32'd0);
    check("rst_instr_count", {24'd0, instr_count}, 32'd0);
    check("rst_cover_hit", {31'd0, cover_hit}, 32'd0);
    check("rst_all_ops", {31'd0, all_ops_covered}, 32'd0);
    check("rst_state", {31'd0, dbg_state}, 32'd0);

    // Single ADD with wrap-around result, then the full op sweep
    run_instr(mkv(T_ARITH, OP_ADD, 32'hFFFF_FFFF, 32'd1, 6'd5, 1, 6'd5, 32'd0, 1'b0, 3'd0), 1'b0, 1'b0);
    check("add_cover_hit", {31'd0, cover_hit}, 32'd0);
    for (int i = 0; i < 14; i++) begin
      run_instr(sweep[i], 1'b0, 1'b0);
      check("sweep_cover_hit", {31'd0, cover_hit}, (e_cnt == 2) ? 32'd1 : 32'd0);
      check("sweep_all_ops", {31'd0, all_ops_covered}, (i == 13) ? 32'd1 : 32'd0);
      check("ns_all_ops", {31'd0, ns_all_ops_covered}, (i >= 10) ? 32'd1 : 32'd0);
    end
    check("ns_check_fail", {31'd0, ns_check_fail}, 32'd1);
    check("ns_fail_code", {29'd0, ns_fail_code}, 32'd5);
    run_instr(mkv(T_ARITH, OP_OPB, 32'd7, 32'd9, 6'd0, 0, 6'd0, 32'd0, 1'b0, 3'd0), 1'b0, 1'b0);

    // Failure codes, one fresh reset per vector
    for (int i = 0; i < 8; i++) begin
      do_reset();
      run_instr(errs[i], 1'b0, 1'b0);
    end

    // Back-to-back retire+decode, then two writes and a later bad SUB
    do_reset();
    v = mkv(T_ARITH, OP_ADD, 32'd1, 32'd2, 6'd4, 1, 6'd4, 32'd3, 1'b0, 3'd0);
    run_instr(v, 1'b0, 1'b1);
    check("b2b_state", {31'd0, dbg_state}, 32'd1);
    run_instr(v, 1'b1, 1'b0);
    check("b2b_cover_hit", {31'd0, cover_hit}, 32'd1);
    run_instr(mkv(T_ARITH, OP_ADD, 32'd1, 32'd2, 6'd3, 2, 6'd3, 32'd3, 1'b0, 3'd1), 1'b0, 1'b0);
    check("two_wr_cover_hit", {31'd0, cover_hit}, 32'd0);
    run_instr(mkv(T_ARITH, OP_SUB, 32'd9, 32'd2, 6'd3, 1, 6'd3, 32'd6, 1'b0, 3'd3), 1'b0, 1'b0);

    // Hang: no completion for TIMEOUT cycles
    do_reset();
    op_type = T_ARITH; op = OP_ADD; rd = 6'd2;
    decode_valid = 1'b1;
    tick();
    decode_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("hang_not_yet", {31'd0, check_fail}, 32'd0);
    check("hang_active", {31'd0, dbg_state}, 32'd1);
    tick();
    check("hang_fail", {31'd0, check_fail}, 32'd1);
    check("hang_code", {29'd0, fail_code}, 32'd6);
    check("hang_idle", {31'd0, dbg_state}, 32'd0);
    check("hang_count", {24'd0, instr_count}, 32'd0);

    // Reset mid-instruction, then a completion with no decode
    do_reset();
    decode_valid = 1'b1;
    tick();
    decode_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_idle", {31'd0, dbg_state}, 32'd0);
    check("midrst_clear", {31'd0, check_fail}, 32'd0);
    instr_complete = 1'b1;
    tick();
    instr_complete = 1'b0;
    check("lone_fail", {31'd0, check_fail}, 32'd1);
    check("lone_code", {29'd0, fail_code}, 32'd7);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
